// File: rtl/counter_pkg.sv
// Shared types for the timer/counter peripheral.
//   mode_e  : what happens when the count passes its terminal value
//   state_e : run state of the counter FSM
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_SAT     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/timer_counter_adder.sv
// Width-bit add/subtract unit with carry/borrow out.
// Ports:
//   i_a, i_b      operands (a +/- b)
//   i_up0_down1   0 = a + b + cin, 1 = a - b - cin
//   i_carry_in    carry (up) or borrow (down) in
//   o_sum         Width-bit result
//   o_carry_out   carry out (up) or borrow out (down)
module timer_counter_adder #(
  parameter int Width = 16
) (
  input  logic [Width-1:0] i_a,
  input  logic [Width-1:0] i_b,
  input  logic             i_up0_down1,
  input  logic             i_carry_in,
  output logic [Width-1:0] o_sum,
  output logic             o_carry_out
);

  logic [Width:0] w_res;

  // One extra bit: for subtraction the top bit of the two's complement
  // difference is set exactly when the result borrowed.
  always_comb begin
    if (!i_up0_down1) begin
      w_res = {1'b0, i_a} + {1'b0, i_b} + {{Width{1'b0}}, i_carry_in};
    end else begin
      w_res = {1'b0, i_a} - {1'b0, i_b} - {{Width{1'b0}}, i_carry_in};
    end
  end

  assign o_sum       = w_res[Width-1:0];
  assign o_carry_out = w_res[Width];

endmodule

// File: rtl/timer_counter.sv
// Programmable up/down counter/timer with prescaler, step, terminal limit,
// compare match and four terminal modes (free-run, wrap, saturate, one-shot).
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start, stop         run control pulses (stop has priority)
//   up0_down1, mode     direction and terminal behaviour
//   step, prescale      increment per tick; tick period = prescale+1 clocks
//   limit, compare      terminal/reload value; match value
//   load, load_count    synchronous load (highest priority)
//   clear_flags         clears sticky overflow
//   count, running      registered count; state == RUNNING
//   wrap, done, match   one-cycle pulses aligned with the new count
//   overflow            sticky terminal flag (FREE/SAT)
module timer_counter
  import counter_pkg::*;
#(
  parameter int               Width         = 16,
  parameter int               PrescaleWidth = 8,
  parameter logic [Width-1:0] Initial       = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     up0_down1,
  input  mode_e                    mode,
  input  logic [Width-1:0]         step,
  input  logic [PrescaleWidth-1:0] prescale,
  input  logic [Width-1:0]         limit,
  input  logic [Width-1:0]         compare,
  input  logic                     load,
  input  logic [Width-1:0]         load_count,
  input  logic                     clear_flags,
  output logic [Width-1:0]         count,
  output logic                     running,
  output logic                     wrap,
  output logic                     done,
  output logic                     match,
  output logic                     overflow
);

  state_e                   r_state, w_state_nxt;
  logic [Width-1:0]         r_count, w_count_nxt;
  logic [PrescaleWidth-1:0] r_pre, w_pre_nxt;
  logic                     r_wrap, w_wrap_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_match, w_match_nxt;
  logic                     r_ovf, w_ovf_nxt;

  logic [Width-1:0]         w_sum;
  logic                     w_carry;
  logic                     w_tick;
  logic                     w_event;
  logic [Width-1:0]         w_tick_count;

  timer_counter_adder #(
    .Width (Width)
  ) u_adder (
    .i_a         (r_count),
    .i_b         (step),
    .i_up0_down1 (up0_down1),
    .i_carry_in  (1'b0),
    .o_sum       (w_sum),
    .o_carry_out (w_carry)
  );

  // >= rather than == so that lowering prescale mid-run cannot strand the
  // prescaler above the new period.
  assign w_tick = (r_state == ST_RUNNING) && (r_pre >= prescale);

  // Terminal event. Up: past limit (FREE: carry out of Width bits).
  // Down: borrow. A zero step never moves the count, so never an event.
  always_comb begin
    w_event = 1'b0;
    if (step != '0) begin
      if (up0_down1) begin
        w_event = w_carry;
      end else if (mode == MODE_FREE) begin
        w_event = w_carry;
      end else begin
        w_event = ({w_carry, w_sum} > {1'b0, limit});
      end
    end
  end

  // Count value a tick would produce.
  always_comb begin
    w_tick_count = w_sum;
    if (w_event) begin
      unique case (mode)
        MODE_FREE:    w_tick_count = w_sum;
        MODE_WRAP:    w_tick_count = up0_down1 ? limit : '0;
        MODE_SAT:     w_tick_count = up0_down1 ? '0 : limit;
        MODE_ONESHOT: w_tick_count = up0_down1 ? '0 : limit;
        default:      w_tick_count = w_sum;
      endcase
    end
  end

  // Next-state / next-output logic. Priority: load > stop > start > tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_match_nxt = 1'b0;
    w_ovf_nxt   = r_ovf & ~clear_flags;

    if (load) begin
      w_count_nxt = load_count;
      w_pre_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (stop) begin
      w_state_nxt = ST_STOPPED;
      w_pre_nxt   = '0;
    end else if (start) begin
      w_state_nxt = ST_RUNNING;
      w_pre_nxt   = '0;
    end else if (r_state == ST_RUNNING) begin
      if (w_tick) begin
        w_pre_nxt   = '0;
        w_count_nxt = w_tick_count;
        w_match_nxt = (w_tick_count == compare);
        if (w_event) begin
          unique case (mode)
            MODE_FREE: begin
              w_wrap_nxt = 1'b1;
              w_ovf_nxt  = 1'b1;
            end
            MODE_WRAP: w_wrap_nxt = 1'b1;
            MODE_SAT:  w_ovf_nxt  = 1'b1;
            MODE_ONESHOT: begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_EXPIRED;
            end
            default: w_wrap_nxt = 1'b0;
          endcase
        end
      end else begin
        w_pre_nxt = r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_STOPPED;
      r_count <= Initial;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
      r_match <= w_match_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count    = r_count;
  assign running  = (r_state == ST_RUNNING);
  assign wrap     = r_wrap;
  assign done     = r_done;
  assign match    = r_match;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;
  import counter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, up0_down1, load, clear_flags;
  mode_e       mode;
  logic [15:0] step, limit, compare, load_count;
  logic [7:0]  prescale;
  logic [15:0] count;
  logic        running, wrap, done, match, overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  timer_counter #(
    .Width         (16),
    .PrescaleWidth (8),
    .Initial       (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .up0_down1   (up0_down1),
    .mode        (mode),
    .step        (step),
    .prescale    (prescale),
    .limit       (limit),
    .compare     (compare),
    .load        (load),
    .load_count  (load_count),
    .clear_flags (clear_flags),
    .count       (count),
    .running     (running),
    .wrap        (wrap),
    .done        (done),
    .match       (match),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; up0_down1 = 1'b0; load = 1'b0;
    clear_flags = 1'b0; mode = MODE_WRAP; step = 16'd3; limit = 16'd10;
    compare = 16'd6; load_count = 16'd0; prescale = 8'd0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // 1: WRAP up, step 3, limit 10
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_running", running, 1);
    chk("t1_cnt_start", count, 0);
    cyc(); chk("t1_cnt3", count, 3);
    cyc(); chk("t1_cnt6", count, 6); chk("t1_match6", match, 1);
    cyc(); chk("t1_cnt9", count, 9); chk("t1_match9", match, 0);
    cyc(); chk("t1_wrapcnt", count, 0); chk("t1_wrap", wrap, 1);
    chk("t1_ovf", overflow, 0);
    cyc(); chk("t1_cnt3b", count, 3); chk("t1_wrap_off", wrap, 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t1_stopped", running, 0);
    cyc(); chk("t1_hold", count, 3);

    // 2: SAT down, step 4, from 10
    mode = MODE_SAT; up0_down1 = 1'b1; step = 16'd4;
    load = 1'b1; load_count = 16'd10; cyc(); load = 1'b0;
    chk("t2_load", count, 10);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); chk("t2_cnt6", count, 6); chk("t2_match6", match, 1);
    cyc(); chk("t2_cnt2", count, 2);
    cyc(); chk("t2_sat0", count, 0); chk("t2_ovf", overflow, 1);
    chk("t2_nowrap", wrap, 0);
    cyc(); chk("t2_hold0", count, 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("t2_ovf_sticky", overflow, 1);
    clear_flags = 1'b1; cyc(); clear_flags = 1'b0;
    chk("t2_ovf_clr", overflow, 0);

    // 3: ONESHOT up, step 1, limit 2, prescale 2
    mode = MODE_ONESHOT; up0_down1 = 1'b0; step = 16'd1; limit = 16'd2; prescale = 8'd2;
    load = 1'b1; load_count = 16'd0; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); chk("t3_pre_wait", count, 0);
    cyc(); chk("t3_cnt1", count, 1);
    cyc(); cyc(); cyc(); chk("t3_cnt2", count, 2); chk("t3_done_early", done, 0);
    cyc(); cyc(); cyc();
    chk("t3_cnt_exp", count, 2); chk("t3_done", done, 1); chk("t3_expired", running, 0);
    cyc(); chk("t3_done_off", done, 0); chk("t3_no_tick", count, 2);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t3_restart", running, 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // 4: FREE, carry and borrow
    mode = MODE_FREE; prescale = 8'd0; step = 16'd1; up0_down1 = 1'b0;
    load = 1'b1; load_count = 16'hFFFE; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); chk("t4_ffff", count, 16'hFFFF); chk("t4_nowrap", wrap, 0);
    cyc(); chk("t4_0000", count, 0); chk("t4_wrap", wrap, 1); chk("t4_ovf", overflow, 1);
    up0_down1 = 1'b1;
    cyc(); chk("t4_down_ffff", count, 16'hFFFF); chk("t4_down_wrap", wrap, 1);
    chk("t4_ovf_sticky", overflow, 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // 5: priority
    load = 1'b1; load_count = 16'h1234; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
    chk("t5_load", count, 16'h1234); chk("t5_state", running, 0);
    chk("t5_ovf_clr", overflow, 0); chk("t5_wrap", wrap, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t5_run", running, 1);
    load = 1'b1; load_count = 16'd5; compare = 16'd5; cyc(); load = 1'b0;
    chk("t5_load_run", count, 5); chk("t5_nomatch", match, 0); chk("t5_still_run", running, 1);
    cyc(); chk("t5_cnt4", count, 4);
    stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
    chk("t5_stop_wins", running, 0); chk("t5_hold", count, 4);

    // 6: async reset mid-run
    up0_down1 = 1'b0;
    load = 1'b1; load_count = 16'hFFFF; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); chk("t6_wrap", wrap, 1);
    cyc(); chk("t6_cnt1", count, 1); chk("t6_ovf", overflow, 1);
    #2; rst = 1'b1; #1;
    chk("t6_rst_cnt", count, 0); chk("t6_rst_run", running, 0);
    chk("t6_rst_ovf", overflow, 0); chk("t6_rst_wrap", wrap, 0);
    rst = 1'b0;
    cyc(); cyc(); chk("t6_no_tick", count, 0); chk("t6_idle", running, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
